dmadd_scan_engine: RTL and testbench
====================================

Name: dmadd_scan_engine

Overview:
Parametrised successor to the 16-bin delta multiply-add block. It accumulates weights into DEPTH bins, then runs a multiplier-free scan that returns one of four results: MIN occupied bin, MAX occupied bin, weighted index sum (sum of w[b]*b, built from two running accumulators), or total weight. It uses a valid/ready load interface and a start/busy/done handshake. It sits beside the multimac datapath as a reduction/statistics engine.

Parameters:
DEPTH, 16, number of bins (power of two, >=4); IDX_W = clog2(DEPTH) derived.
DATA_W, 4, width of unsigned load weight.
W_W, 8, bin width; bins saturate at 2^W_W-1.
CNT_W (derived) = W_W+IDX_W; OUT_W (derived) = W_W+2*IDX_W.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous clear of bins/result; aborts scan.
load_valid  in  1  load request.
load_ready  out  1  = (state==IDLE) && !clear.
load_idx  in  IDX_W  target bin.
load_data  in  DATA_W  weight to add.
start  in  1  begin scan (accepted only in IDLE).
mode  in  2  00 MIN, 01 MAX, 10 WSUM, 11 SUM; sampled on start.
busy  out  1  high in SCAN and DONE.
done  out  1  one-cycle pulse when result is ready.
result_valid  out  1  result holds a valid value.
result  out  OUT_W  scan result, zero-extended.
empty  out  1  MIN/MAX found no occupied bin.
sat  out  1  sticky: some bin has saturated since the last clear/reset.

Behaviour:
- Reset (async): all bins 0; state IDLE; busy, done, result_valid, empty, sat = 0; result = 0.
- FSM IDLE -> SCAN -> DONE -> IDLE. clear in any state: bins, result, result_valid, empty and sat -> 0; go to IDLE next cycle; no done pulse.
- Load: on load_valid && load_ready, w[load_idx] <= min(w + load_data, 2^W_W-1); on saturation, sat <= 1.
- Start: in IDLE on start && !clear, latch mode, clear result_valid, enter SCAN next cycle. If a load is accepted in the same cycle, it is applied first and included in the scan. start outside IDLE is ignored.
- SCAN examines one bin per cycle. Start accepted at cycle T; the k-th examined bin is read at T+1+k.
- MIN: pointer 0 upward. On the first bin with w != 0, result <= index and go to DONE.
- MAX: pointer DEPTH-1 downward; same hit rule.
- MIN/MAX with no hit after all DEPTH bins: result <= 0, empty <= 1. A hit sets empty <= 0.
- WSUM/SUM: pointer DEPTH-1 down to 0, DEPTH cycles. Each step: total <= total + cnt (old value), then cnt <= cnt + w[b]. cnt and total are zeroed on start.
  - Final total = sum of w[b]*b. Final cnt = sum of w[b].
  - WSUM result = total; SUM result = zero-extended cnt.
  - Widths cannot overflow: cnt is CNT_W bits, total is OUT_W bits.
- Hit on bin m (MIN): done at T+2+m. MAX hit on bin m: done at T+2+(DEPTH-1-m). Full scan: done at T+DEPTH+1.
- DONE lasts one cycle: done=1, result_valid <= 1, then IDLE.
- result and result_valid hold until the next accepted start, clear, or reset.
- Bins are not modified by a scan; repeated scans return identical results.
- load_idx covers all bins, so any index is valid; no wrap-around handling is needed.

Decomposition:
- Package dmadd_pkg: mode enum (MODE_MIN, MODE_MAX, MODE_WSUM, MODE_SUM), state enum (S_IDLE, S_SCAN, S_DONE), width helper functions for CNT_W/OUT_W.
- Sub-module dmadd_bin_array: DEPTH x W_W registers, saturating write port, async-read port, single-cycle clear, sat flag.
- The scan FSM and accumulators stay in the top.

Test Plan (DEPTH=16, DATA_W=4, W_W=8):
1. Empty bins, after reset: start MIN at T -> done at T+17, empty=1, result=0, result_valid=1.
2. Load (3,5), (9,2), (9,4), then:
   - MIN -> result=3, done at T+5.
   - MAX -> result=9, done at T+8.
3. Same bins, then:
   - WSUM -> result=69 (3*5 + 9*6), done at T+17.
   - SUM -> result=11.
   - Repeat WSUM -> 69 again.
4. Load (2,15) 20 times -> bin 2 = 255, sat=1; WSUM -> 510. clear -> sat=0, SUM -> 0.
5. Start WSUM, assert clear at T+5 -> busy=0 at T+6, no done, result_valid=0. load_ready is low during the scan. Subsequent SUM -> 0.
6. Load and start in the same cycle, then reset:
   - load (0,7) with start MIN in the same cycle -> result=0, empty=0.
   - assert rst_n low mid-scan -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/dmadd_pkg.sv
// ============================================================================
// Module  : dmadd_pkg
// Brief   : Shared types, FSM encodings and width helpers for the scan engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmadd_pkg;

  typedef enum logic [1:0] {
    MODE_MIN  = 2'b00,
    MODE_MAX  = 2'b01,
    MODE_WSUM = 2'b10,
    MODE_SUM  = 2'b11
  } mode_e;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // A bin count times DEPTH entries fits in W_W+IDX_W bits; times an index adds another IDX_W.
  function automatic int cnt_width(input int w_w, input int idx_w);
    return w_w + idx_w;
  endfunction

  function automatic int out_width(input int w_w, input int idx_w);
    return w_w + 2 * idx_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmadd_scan_engine_if.sv
// ============================================================================
// Module  : dmadd_scan_engine_if
// Brief   : Load, control and result bundle of the scan engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmadd_scan_engine_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int W_W    = 8
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OUT_W = dmadd_pkg::out_width(W_W, IDX_W);

  logic              clear;
  logic              load_valid;
  logic              load_ready;
  logic [IDX_W-1:0]  load_idx;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [OUT_W-1:0]  result;
  logic              empty;
  logic              sat;

  modport slave (
    input  clear, load_valid, load_idx, load_data, start, mode,
    output load_ready, busy, done, result_valid, result, empty, sat
  );

  modport master (
    output clear, load_valid, load_idx, load_data, start, mode,
    input  load_ready, busy, done, result_valid, result, empty, sat
  );

endinterface

`default_nettype wire

// File: rtl/dmadd_bin_array.sv
// ============================================================================
// Module  : dmadd_bin_array
// Brief   : DEPTH saturating weight bins with one write and one async read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmadd_bin_array #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int W_W    = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clear,
  input  wire logic              wr_en,
  input  wire logic [IDX_W-1:0]  wr_idx,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic [IDX_W-1:0]  rd_idx,
  output logic      [W_W-1:0]    rd_data,
  output logic                   sat
);

  logic [W_W-1:0] r_bins [DEPTH];
  logic           r_sat;
  logic [W_W:0]   w_sum;
  logic           w_ovf;
  logic [W_W-1:0] w_wr_val;

  // One extra bit catches the carry out so the write can clamp to all ones.
  assign w_sum    = {1'b0, r_bins[wr_idx]} + (W_W+1)'(wr_data);
  assign w_ovf    = w_sum[W_W];
  assign w_wr_val = w_ovf ? '1 : w_sum[W_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bins[i] <= '0;
      r_sat <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_bins[i] <= '0;
      r_sat <= 1'b0;
    end else if (wr_en) begin
      r_bins[wr_idx] <= w_wr_val;
      if (w_ovf) r_sat <= 1'b1;
    end
  end

  assign rd_data = r_bins[rd_idx];
  assign sat     = r_sat;

endmodule

`default_nettype wire

// File: rtl/dmadd_scan_engine.sv
// ============================================================================
// Module  : dmadd_scan_engine
// Brief   : Bin accumulator with a one-bin-per-cycle MIN/MAX/WSUM/SUM scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmadd_scan_engine
  import dmadd_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int W_W    = 8
) (
  input wire logic          clk,
  input wire logic          rst_n,
  dmadd_scan_engine_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(W_W, IDX_W);
  localparam int OUT_W = out_width(W_W, IDX_W);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(DEPTH - 1);

  state_t           r_state;
  mode_e            r_mode;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_total;
  logic [OUT_W-1:0] r_result;
  logic             r_result_valid;
  logic             r_empty;

  logic             w_load_accept;
  logic             w_minmax;
  logic             w_hit;
  logic             w_last;
  logic [W_W-1:0]   w_rd_data;
  logic [CNT_W-1:0] w_cnt_next;
  logic [OUT_W-1:0] w_total_next;

  assign bus.load_ready = (r_state == S_IDLE) && !bus.clear;
  assign w_load_accept  = bus.load_valid && bus.load_ready;

  dmadd_bin_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .W_W    (W_W)
  ) u_bins (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.clear),
    .wr_en   (w_load_accept),
    .wr_idx  (bus.load_idx),
    .wr_data (bus.load_data),
    .rd_idx  (r_ptr),
    .rd_data (w_rd_data),
    .sat     (bus.sat)
  );

  assign w_minmax     = (r_mode == MODE_MIN) || (r_mode == MODE_MAX);
  assign w_hit        = (w_rd_data != '0);
  assign w_last       = (r_mode == MODE_MIN) ? (r_ptr == c_LAST) : (r_ptr == '0);
  // Descending walk: adding the running count once per step weights each bin by its index.
  assign w_total_next = r_total + OUT_W'(r_cnt);
  assign w_cnt_next   = r_cnt + CNT_W'(w_rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_mode         <= MODE_MIN;
      r_ptr          <= '0;
      r_cnt          <= '0;
      r_total        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_empty        <= 1'b0;
    end else if (bus.clear) begin
      r_state        <= S_IDLE;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_empty        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode         <= mode_e'(bus.mode);
            r_ptr          <= (bus.mode == MODE_MIN) ? '0 : c_LAST;
            r_cnt          <= '0;
            r_total        <= '0;
            r_result_valid <= 1'b0;
            r_empty        <= 1'b0;
            r_state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_minmax) begin
            if (w_hit) begin
              r_result <= OUT_W'(r_ptr);
              r_empty  <= 1'b0;
              r_state  <= S_DONE;
            end else if (w_last) begin
              r_result <= '0;
              r_empty  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_ptr <= (r_mode == MODE_MIN) ? r_ptr + 1'b1 : r_ptr - 1'b1;
            end
          end else begin
            r_cnt   <= w_cnt_next;
            r_total <= w_total_next;
            if (w_last) begin
              r_result <= (r_mode == MODE_WSUM) ? w_total_next : OUT_W'(w_cnt_next);
              r_state  <= S_DONE;
            end else begin
              r_ptr <= r_ptr - 1'b1;
            end
          end
        end
        S_DONE: begin
          r_result_valid <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state == S_SCAN) || (r_state == S_DONE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.result_valid = r_result_valid;
  assign bus.result       = r_result;
  assign bus.empty        = r_empty;

endmodule

`default_nettype wire

// File: tb/tb_dmadd_scan_engine.sv
// ============================================================================
// Module  : tb_dmadd_scan_engine
// Brief   : Scoreboard bench with a plain-arithmetic bin model for the scan engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmadd_scan_engine;
  import dmadd_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 4;
  localparam int W_W    = 8;
  localparam int MAXW   = (1 << W_W) - 1;

  typedef struct {
    logic [31:0] result;
    logic        empty;
    logic        chk_empty;
    logic [1:0]  mode;
    int          exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmadd_scan_engine_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .W_W(W_W)) bus ();

  dmadd_scan_engine #(.DEPTH(DEPTH), .DATA_W(DATA_W), .W_W(W_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   model [DEPTH];
  bit   model_sat;
  exp_t sb [$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Checker: every done pulse must match the oldest outstanding scan.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no pending scan (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result_mode%0d", mon_e.mode), {16'd0, bus.result}, mon_e.result);
        check($sformatf("done_cycle_mode%0d", mon_e.mode), cyc, mon_e.exp_cyc);
        if (mon_e.chk_empty) check($sformatf("empty_mode%0d", mon_e.mode), {31'd0, bus.empty}, {31'd0, mon_e.empty});
      end
    end
  end

  function automatic void model_load(input int idx, input int d);
    int s;
    s = model[idx] + d;
    if (s > MAXW) begin
      s = MAXW;
      model_sat = 1'b1;
    end
    model[idx] = s;
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < DEPTH; b++) model[b] = 0;
    model_sat = 1'b0;
  endfunction

  function automatic exp_t model_scan(input logic [1:0] m, input int t);
    exp_t e;
    e.result    = 0;
    e.empty     = 1'b0;
    e.chk_empty = (m == 2'b00) || (m == 2'b01);
    e.mode      = m;
    e.exp_cyc   = t + DEPTH + 1;
    case (m)
      2'b00: begin
        e.empty = 1'b1;
        for (int b = DEPTH - 1; b >= 0; b--)
          if (model[b] != 0) begin
            e.result = b; e.empty = 1'b0; e.exp_cyc = t + 2 + b;
          end
      end
      2'b01: begin
        e.empty = 1'b1;
        for (int b = 0; b < DEPTH; b++)
          if (model[b] != 0) begin
            e.result = b; e.empty = 1'b0; e.exp_cyc = t + 2 + (DEPTH - 1 - b);
          end
      end
      2'b10: for (int b = 0; b < DEPTH; b++) e.result += model[b] * b;
      default: for (int b = 0; b < DEPTH; b++) e.result += model[b];
    endcase
    return e;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL scan_timeout: got busy=%0d after 60 cycles, expected idle", bus.busy);
      sb.delete();
    end
  endtask

  task automatic do_load(input int idx, input int d);
    @(negedge clk);
    check("load_ready_idle", {31'd0, bus.load_ready}, 32'd1);
    bus.load_valid = 1'b1;
    bus.load_idx   = idx[3:0];
    bus.load_data  = d[3:0];
    model_load(idx, d);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    model_clear();
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic do_scan(input logic [1:0] m, input bit with_load, input int li, input int ld);
    @(negedge clk);
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_idx   = li[3:0];
      bus.load_data  = ld[3:0];
      model_load(li, ld);
    end
    bus.start = 1'b1;
    bus.mode  = m;
    sb.push_back(model_scan(m, cyc));
    @(negedge clk);
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    wait_idle();
    check("result_valid_after_done", {31'd0, bus.result_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"},  {31'd0, bus.done}, 32'd0);
    check({tag, "_rvalid"}, {31'd0, bus.result_valid}, 32'd0);
    check({tag, "_result"}, {16'd0, bus.result}, 32'd0);
    check({tag, "_empty"}, {31'd0, bus.empty}, 32'd0);
    check({tag, "_sat"},   {31'd0, bus.sat}, 32'd0);
  endtask

  initial begin
    bus.clear = 1'b0; bus.load_valid = 1'b0; bus.load_idx = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.mode = 2'b00;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_load_ready", {31'd0, bus.load_ready}, 32'd1);

    // Empty bins, then a small known population.
    do_scan(2'b00, 0, 0, 0);
    do_load(3, 5); do_load(9, 2); do_load(9, 4);
    do_scan(2'b00, 0, 0, 0);
    do_scan(2'b01, 0, 0, 0);
    do_scan(2'b10, 0, 0, 0);
    do_scan(2'b11, 0, 0, 0);
    do_scan(2'b10, 0, 0, 0);

    // Saturation and its clear.
    do_clear();
    for (int i = 0; i < 20; i++) do_load(2, 15);
    check("sat_set", {31'd0, bus.sat}, 32'd1);
    do_scan(2'b10, 0, 0, 0);
    do_clear();
    check("sat_cleared", {31'd0, bus.sat}, 32'd0);
    do_scan(2'b11, 0, 0, 0);

    // Clear aborting a scan.
    do_load(7, 9); do_load(12, 3);
    begin
      int t;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = 2'b10; t = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("load_ready_in_scan", {31'd0, bus.load_ready}, 32'd0);
      check("busy_in_scan", {31'd0, bus.busy}, 32'd1);
      while (cyc < t + 5) @(negedge clk);
      bus.clear = 1'b1;
      model_clear();
      @(negedge clk);
      bus.clear = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_rvalid", {31'd0, bus.result_valid}, 32'd0);
      repeat (20) @(negedge clk);
    end
    do_scan(2'b11, 0, 0, 0);

    // Randomized loads, clears and scans.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) do_clear();
      for (int k = $urandom_range(0, 4); k > 0; k--)
        do_load($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      do_scan(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(0, DEPTH - 1),
              $urandom_range(1, 15));
    end

    // Load accepted together with start, then async reset mid-scan.
    do_clear();
    do_scan(2'b00, 1, 0, 7);
    for (int i = 0; i < 18; i++) do_load(5, 15);
    check("sat_before_reset", {31'd0, bus.sat}, 32'd1);
    do_scan(2'b11, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
